// File: rtl/matmul_scheduler.sv
// matmul_scheduler: walks every cell (i,j) of a size x size matrix product C = A*B, handing
// row i of A and column j of B to a single column_processor and storing each returned cell.
// The finished matrix is held on out_mat_c and offered through an out_ready/out_ack handshake.
// Optional build macro MATMUL_SCHED_TIMEOUT_EN adds a WAIT/ACK watchdog (parameter
// timeout_cycles, output out_timeout); without it the scheduler waits on the processor forever.
module matmul_scheduler #(
   parameter int unsigned size       = 2,
   parameter int unsigned cell_width = 32,
   parameter int unsigned width      = cell_width * size,
   parameter int unsigned mat_width  = width * size
`ifdef MATMUL_SCHED_TIMEOUT_EN
   ,
   parameter int unsigned timeout_cycles = 4096
`endif
) (
   input  logic                 in_clk,
   input  logic                 in_reset,
   input  logic                 in_ready,
   input  logic [mat_width-1:0] in_mat_a,
   input  logic [mat_width-1:0] in_mat_b,
   input  logic                 out_ack,
   output logic [mat_width-1:0] out_mat_c,
   output logic                 out_ready,
   output logic                 out_busy,
   output logic                 out_proc_ready,
   output logic [width-1:0]     out_proc_row_a,
   output logic [width-1:0]     out_proc_col_b,
   output logic                 out_proc_ack,
   input  logic                 in_proc_ready,
   input  logic [width-1:0]     in_proc_cell_c
`ifdef MATMUL_SCHED_TIMEOUT_EN
   ,
   output logic                 out_timeout
`endif
);

   // Index counters stay at least one bit wide so size=1 still elaborates.
   localparam int unsigned idx_w = (size > 1) ? $clog2(size) : 1;
   localparam logic [idx_w-1:0] last_idx = idx_w'(size - 1);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StAck,
      StDone
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [idx_w-1:0]     r_i, w_i_nxt;
   logic [idx_w-1:0]     r_j, w_j_nxt;
   logic                 r_ready, w_ready_nxt;
   logic                 r_busy, w_busy_nxt;
   logic                 r_proc_ready, w_proc_ready_nxt;
   logic                 r_proc_ack, w_proc_ack_nxt;

   logic [mat_width-1:0] r_mat_a, r_mat_b, r_mat_c;
   logic [width-1:0]     r_row, r_col;
   logic [width-1:0]     w_row, w_col;
   logic                 w_load, w_issue, w_store;
   logic [cell_width-1:0] w_store_val;
   int unsigned          w_cell_base;

`ifdef MATMUL_SCHED_TIMEOUT_EN
   localparam int unsigned tmo_w = $clog2(timeout_cycles + 1);
   logic [tmo_w-1:0]     r_tmo_cnt, w_tmo_cnt_nxt;
   logic                 r_timeout, w_timeout_nxt;
   logic                 w_tmo_hit;

   assign w_tmo_hit   = (r_tmo_cnt == tmo_w'(timeout_cycles - 1));
   assign out_timeout = r_timeout;
`endif

   // Only the low cell of the processor result carries data.
   generate
      if (width > cell_width) begin : g_unused_cell
         logic w_unused_cell_hi;
         assign w_unused_cell_hi = ^in_proc_cell_c[width-1:cell_width];
      end
   endgenerate

   // Row i of A is contiguous in row-major packing; column j of B is gathered cell by cell.
   assign w_row       = r_mat_a[32'(r_i) * width +: width];
   assign w_cell_base = (32'(r_i) * size + 32'(r_j)) * cell_width;

   // Gather column j of B into the processor vector layout.
   always_comb begin
      w_col = '0;
      for (int unsigned k = 0; k < size; k++) begin
         w_col[k * cell_width +: cell_width] =
            r_mat_b[(k * size + 32'(r_j)) * cell_width +: cell_width];
      end
   end

   // Next-state and next registered-output logic for the cell sequencer.
   always_comb begin
      w_state_nxt      = r_state;
      w_i_nxt          = r_i;
      w_j_nxt          = r_j;
      w_ready_nxt      = r_ready;
      w_busy_nxt       = r_busy;
      w_proc_ready_nxt = 1'b0;
      w_proc_ack_nxt   = r_proc_ack;
      w_load           = 1'b0;
      w_issue          = 1'b0;
      w_store          = 1'b0;
      w_store_val      = in_proc_cell_c[cell_width-1:0];
`ifdef MATMUL_SCHED_TIMEOUT_EN
      w_tmo_cnt_nxt    = r_tmo_cnt;
      w_timeout_nxt    = r_timeout;
`endif
      unique case (r_state)
         StIdle: begin
            if (in_ready) begin
               w_load      = 1'b1;
               w_i_nxt     = '0;
               w_j_nxt     = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = StIssue;
`ifdef MATMUL_SCHED_TIMEOUT_EN
               w_timeout_nxt = 1'b0;
`endif
            end
         end
         StIssue: begin
            w_issue          = 1'b1;
            w_proc_ready_nxt = 1'b1;
            w_state_nxt      = StWait;
`ifdef MATMUL_SCHED_TIMEOUT_EN
            w_tmo_cnt_nxt    = '0;
`endif
         end
         StWait: begin
            if (in_proc_ready) begin
               w_store        = 1'b1;
               w_proc_ack_nxt = 1'b1;
               w_state_nxt    = StAck;
`ifdef MATMUL_SCHED_TIMEOUT_EN
               w_tmo_cnt_nxt  = '0;
            end else if (w_tmo_hit) begin
               w_store       = 1'b1;
               w_store_val   = '0;
               w_timeout_nxt = 1'b1;
               w_ready_nxt   = 1'b1;
               w_state_nxt   = StDone;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
`endif
            end
         end
         StAck: begin
            // Processor drops its ready once it has seen our ack and left its DONE state.
            if (!in_proc_ready) begin
               w_proc_ack_nxt = 1'b0;
               if (r_i == last_idx && r_j == last_idx) begin
                  w_i_nxt     = '0;
                  w_j_nxt     = '0;
                  w_ready_nxt = 1'b1;
                  w_state_nxt = StDone;
               end else begin
                  if (r_j == last_idx) begin
                     w_j_nxt = '0;
                     w_i_nxt = r_i + 1'b1;
                  end else begin
                     w_j_nxt = r_j + 1'b1;
                  end
                  w_state_nxt = StIssue;
               end
`ifdef MATMUL_SCHED_TIMEOUT_EN
            end else if (w_tmo_hit) begin
               w_store        = 1'b1;
               w_store_val    = '0;
               w_proc_ack_nxt = 1'b0;
               w_timeout_nxt  = 1'b1;
               w_ready_nxt    = 1'b1;
               w_state_nxt    = StDone;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;
`endif
            end
         end
         StDone: begin
            // in_ready is deliberately ignored here; a new request is taken in IDLE.
            if (out_ack) begin
               w_ready_nxt = 1'b0;
               w_busy_nxt  = 1'b0;
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Control state and registered handshake outputs.
   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_state      <= StIdle;
         r_i          <= '0;
         r_j          <= '0;
         r_ready      <= 1'b0;
         r_busy       <= 1'b0;
         r_proc_ready <= 1'b0;
         r_proc_ack   <= 1'b0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
         r_tmo_cnt    <= '0;
         r_timeout    <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_i          <= w_i_nxt;
         r_j          <= w_j_nxt;
         r_ready      <= w_ready_nxt;
         r_busy       <= w_busy_nxt;
         r_proc_ready <= w_proc_ready_nxt;
         r_proc_ack   <= w_proc_ack_nxt;
`ifdef MATMUL_SCHED_TIMEOUT_EN
         r_tmo_cnt    <= w_tmo_cnt_nxt;
         r_timeout    <= w_timeout_nxt;
`endif
      end
   end

   // Operand/result storage and the row/column vectors held for the processor.
   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         r_mat_a <= '0;
         r_mat_b <= '0;
         r_mat_c <= '0;
         r_row   <= '0;
         r_col   <= '0;
      end else begin
         if (w_load) begin
            r_mat_a <= in_mat_a;
            r_mat_b <= in_mat_b;
            r_mat_c <= '0;
         end
         if (w_issue) begin
            r_row <= w_row;
            r_col <= w_col;
         end
         if (w_store) begin
            r_mat_c[w_cell_base +: cell_width] <= w_store_val;
         end
      end
   end

   assign out_mat_c      = r_mat_c;
   assign out_ready      = r_ready;
   assign out_busy       = r_busy;
   assign out_proc_ready = r_proc_ready;
   assign out_proc_ack   = r_proc_ack;
   assign out_proc_row_a = r_row;
   assign out_proc_col_b = r_col;

endmodule

// File: tb/tb_matmul_scheduler.sv
// tb_matmul_scheduler: directed checks of matmul_scheduler (size=2, 32-bit cells) driving a
// behavioural column_processor stand-in that handles scaled-identity B operands.
module tb_matmul_scheduler;

   localparam int unsigned MW = 128;
   localparam int unsigned W  = 64;

   logic          in_clk = 1'b0;
   logic          in_reset;
   logic          in_ready;
   logic [MW-1:0] in_mat_a, in_mat_b;
   logic          out_ack;
   logic [MW-1:0] out_mat_c;
   logic          out_ready, out_busy, out_proc_ready, out_proc_ack;
   logic [W-1:0]  out_proc_row_a, out_proc_col_b;
   logic          in_proc_ready;
   logic [W-1:0]  in_proc_cell_c;
`ifdef MATMUL_SCHED_TIMEOUT_EN
   logic          out_timeout;
`endif

   matmul_scheduler #(
      .size       (2),
      .cell_width (32)
`ifdef MATMUL_SCHED_TIMEOUT_EN
      ,
      .timeout_cycles (16)
`endif
   ) u_dut (
      .in_clk         (in_clk),
      .in_reset       (in_reset),
      .in_ready       (in_ready),
      .in_mat_a       (in_mat_a),
      .in_mat_b       (in_mat_b),
      .out_ack        (out_ack),
      .out_mat_c      (out_mat_c),
      .out_ready      (out_ready),
      .out_busy       (out_busy),
      .out_proc_ready (out_proc_ready),
      .out_proc_row_a (out_proc_row_a),
      .out_proc_col_b (out_proc_col_b),
      .out_proc_ack   (out_proc_ack),
      .in_proc_ready  (in_proc_ready),
      .in_proc_cell_c (in_proc_cell_c)
`ifdef MATMUL_SCHED_TIMEOUT_EN
      ,
      .out_timeout    (out_timeout)
`endif
   );

   always #5 in_clk = ~in_clk;

   // Matrices, row-major, cell (r,c) at [(r*2+c)*32 +: 32].
   localparam logic [MW-1:0] MAT_A  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
   localparam logic [MW-1:0] MAT_I  = {32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000};
   localparam logic [MW-1:0] MAT_2I = {32'h40000000, 32'h00000000, 32'h00000000, 32'h40000000};
   localparam logic [MW-1:0] MAT_C3 = {32'h41000000, 32'h40C00000, 32'h40800000, 32'h40000000};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Stand-in processor: B columns are scaled unit vectors, so the dot product is a single
   // A element times 1.0 (unchanged) or 2.0 (exponent + 1).
   function automatic logic [31:0] stub_dot(input logic [W-1:0] row, input logic [W-1:0] col);
      logic [31:0] r;
      r = 32'h0;
      for (int k = 0; k < 2; k++) begin
         if (col[k*32 +: 32] == 32'h3F800000) begin
            r = row[k*32 +: 32];
         end else if (col[k*32 +: 32] == 32'h40000000 && row[k*32 +: 32] != 32'h0) begin
            r = row[k*32 +: 32] + 32'h00800000;
         end
      end
      return r;
   endfunction

   logic         stub_en = 1'b1;
   logic [1:0]   stub_st;
   int           stub_cnt;
   logic [W-1:0] last_row, last_col;
   int           n_pulses = 0;
   logic         prev_pr = 1'b0;

   // Processor model sharing the scheduler reset.
   always @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         stub_st        <= 2'd0;
         stub_cnt       <= 0;
         in_proc_ready  <= 1'b0;
         in_proc_cell_c <= '0;
      end else begin
         case (stub_st)
            2'd0: if (out_proc_ready && stub_en) begin
               last_row <= out_proc_row_a;
               last_col <= out_proc_col_b;
               stub_cnt <= 0;
               stub_st  <= 2'd1;
            end
            2'd1: if (stub_cnt == 2) begin
               in_proc_ready  <= 1'b1;
               // Upper half is junk the scheduler must drop.
               in_proc_cell_c <= {32'hDEADBEEF, stub_dot(last_row, last_col)};
               stub_st        <= 2'd2;
            end else begin
               stub_cnt <= stub_cnt + 1;
            end
            2'd2: if (out_proc_ack) begin
               in_proc_ready <= 1'b0;
               stub_st       <= 2'd0;
            end
            default: stub_st <= 2'd0;
         endcase
      end
   end

   // Count rising edges of the issue strobe.
   always @(posedge in_clk) begin
      if (out_proc_ready && !prev_pr) n_pulses <= n_pulses + 1;
      prev_pr <= out_proc_ready;
   end

   task automatic start_run(input logic [MW-1:0] a, input logic [MW-1:0] b);
      @(negedge in_clk);
      in_mat_a = a;
      in_mat_b = b;
      in_ready = 1'b1;
      @(negedge in_clk);
      in_ready = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int cycles);
      bit ok;
      ok     = 1'b0;
      cycles = 0;
      for (int n = 0; n < 300; n++) begin
         @(negedge in_clk);
         cycles++;
         if (out_ready) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, MW'(ok), MW'(1));
   endtask

   task automatic pulse_ack();
      @(negedge in_clk);
      out_ack = 1'b1;
      @(negedge in_clk);
      out_ack = 1'b0;
   endtask

   initial begin
      int cyc;
      int base;
      int stable;
      bit seen;

      in_reset = 1'b0;
      in_ready = 1'b0;
      in_mat_a = '0;
      in_mat_b = '0;
      out_ack  = 1'b0;

      // Reset values.
      #12;
      check("rst_ready", MW'(out_ready), MW'(0));
      check("rst_busy", MW'(out_busy), MW'(0));
      check("rst_proc_ready", MW'(out_proc_ready), MW'(0));
      check("rst_proc_ack", MW'(out_proc_ack), MW'(0));
      check("rst_mat_c", out_mat_c, MW'(0));
      check("rst_row_col", MW'({out_proc_row_a, out_proc_col_b}), MW'(0));
      @(negedge in_clk);
      in_reset = 1'b1;

      // A * I = A.
      start_run(MAT_A, MAT_I);
      check("busy_after_accept", MW'(out_busy), MW'(1));
      wait_done("done_ident", cyc);
      check("c_ident", out_mat_c, MAT_A);
      check("last_row", MW'(last_row), MW'({32'h40800000, 32'h40400000}));
      check("last_col", MW'(last_col), MW'({32'h3F800000, 32'h00000000}));
      pulse_ack();
      check("idle_ready", MW'(out_ready), MW'(0));
      check("idle_busy", MW'(out_busy), MW'(0));
      check("idle_c_held", out_mat_c, MAT_A);

      // A * 2I.
      start_run(MAT_A, MAT_2I);
      wait_done("done_2i", cyc);
      check("c_2i", out_mat_c, MAT_C3);
      pulse_ack();

      // in_ready held high through a whole run: one issue per cell, no restart before IDLE.
      base = n_pulses;
      @(negedge in_clk);
      in_mat_a = MAT_A;
      in_mat_b = MAT_I;
      in_ready = 1'b1;
      wait_done("done_held", cyc);
      check("pulses_per_run", MW'(n_pulses - base), MW'(4));
      repeat (3) @(negedge in_clk);
      check("done_hold_busy", MW'(out_busy), MW'(1));
      check("done_no_reissue", MW'(n_pulses - base), MW'(4));
      pulse_ack();
      check("ack_wins_ready", MW'(out_ready), MW'(0));
      check("ack_wins_busy", MW'(out_busy), MW'(0));
      @(negedge in_clk);
      check("restart_in_idle", MW'(out_busy), MW'(1));
      in_ready = 1'b0;
      wait_done("done_restart", cyc);

      // DONE held 100 cycles without ack; a new request mid-way is ignored.
      base   = n_pulses;
      stable = 0;
      for (int n = 0; n < 100; n++) begin
         in_ready = (n >= 50 && n < 53);
         in_mat_b = (n >= 50 && n < 53) ? MAT_2I : MAT_I;
         @(negedge in_clk);
         if (out_ready && out_busy && out_mat_c == MAT_A) stable++;
      end
      in_ready = 1'b0;
      check("done_stable", MW'(stable), MW'(100));
      check("done_ignore_req", MW'(n_pulses - base), MW'(0));
      pulse_ack();

      // Reset pulsed during WAIT clears everything immediately, processor included.
      start_run(MAT_A, MAT_2I);
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge in_clk);
         if (out_proc_ready) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_reached", MW'(seen), MW'(1));
      #2;
      in_reset = 1'b0;
      #1;
      check("mid_rst_flags",
            MW'({out_ready, out_busy, out_proc_ready, out_proc_ack, in_proc_ready}), MW'(0));
      check("mid_rst_mat_c", out_mat_c, MW'(0));
      check("mid_rst_row_col", MW'({out_proc_row_a, out_proc_col_b}), MW'(0));
      @(negedge in_clk);
      in_reset = 1'b1;
      repeat (2) @(negedge in_clk);
      check("post_rst_idle", MW'({out_busy, out_ready}), MW'(0));

      // Recovery after reset.
      start_run(MAT_A, MAT_2I);
      wait_done("done_after_rst", cyc);
      check("c_after_rst", out_mat_c, MAT_C3);
      pulse_ack();

`ifdef MATMUL_SCHED_TIMEOUT_EN
      // Processor never answers: watchdog forces DONE with C(0,0)=0.
      stub_en = 1'b0;
      start_run(MAT_A, MAT_I);
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge in_clk);
         if (out_proc_ready) begin
            seen = 1'b1;
            break;
         end
      end
      check("tmo_wait_reached", MW'(seen), MW'(1));
      wait_done("tmo_done", cyc);
      check("tmo_latency", MW'(cyc), MW'(16));
      check("tmo_flag", MW'(out_timeout), MW'(1));
      check("tmo_c00", MW'(out_mat_c[31:0]), MW'(0));
      pulse_ack();
      check("tmo_sticky", MW'(out_timeout), MW'(1));
      stub_en = 1'b1;
      start_run(MAT_A, MAT_I);
      check("tmo_cleared", MW'(out_timeout), MW'(0));
      wait_done("tmo_recover", cyc);
      pulse_ack();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
